// File: rtl/rtc_bus_arbiter.sv
// RTC bus arbiter: fixed-priority write requesters plus a permanent reader,
// with read fairness and a protocol-engine watchdog.
module rtc_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned RD_FAIR     = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [3:0]  ack,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic [7:0]  rd_addr_o,
  output logic        proto_start,
  output logic        proto_write,
  output logic [7:0]  proto_addr,
  output logic [7:0]  proto_data,
  input  logic        proto_done,
  input  logic [7:0]  proto_rdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] src_q, src_d;
  logic       rd_q, rd_d;
  logic       start_q, start_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [3:0] ack_q, ack_d;
  logic       rdv_q, rdv_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] rdaddr_q, rdaddr_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic [3:0] fair_q, fair_d;
  logic [9:0] wcnt_q, wcnt_d;

  logic       force_rd;
  logic [1:0] wr_idx;

  assign force_rd = rd_en && (fair_q == 4'(RD_FAIR));

  always_comb begin
    wr_idx = 2'd3;
    if (req[0])      wr_idx = 2'd0;
    else if (req[1]) wr_idx = 2'd1;
    else if (req[2]) wr_idx = 2'd2;
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    rd_d     = rd_q;
    start_d  = 1'b0;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ack_d    = 4'b0000;
    rdv_d    = 1'b0;
    rdata_d  = rdata_q;
    rdaddr_d = rdaddr_q;
    tmo_d    = tmo_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if ((|req) || rd_en) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
          if (force_rd || (req == 4'b0000)) begin
            rd_d    = 1'b1;
            write_d = 1'b0;
            addr_d  = rd_addr;
            data_d  = 8'h00;
          end else begin
            rd_d    = 1'b0;
            src_d   = wr_idx;
            write_d = 1'b1;
            addr_d  = req_addr[{wr_idx, 3'b000} +: 8];
            data_d  = req_data[{wr_idx, 3'b000} +: 8];
          end
        end
      end
      S_ISSUE: begin
        wcnt_d  = 10'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the timeout cycle still wins over the abort.
        if (proto_done) begin
          state_d = S_IDLE;
          if (rd_q) begin
            rdv_d    = 1'b1;
            rdata_d  = proto_rdata;
            rdaddr_d = addr_q;
          end else begin
            ack_d[src_q] = 1'b1;
          end
        end else if (wcnt_q == 10'(TIMEOUT_CYC)) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fair_d = fair_q;
    if (!rd_en) begin
      fair_d = 4'd0;
    end else if ((state_q == S_WAIT) && proto_done) begin
      if (rd_q)                 fair_d = 4'd0;
      else if (fair_q != 4'hF)  fair_d = fair_q + 4'd1;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      src_q    <= 2'd0;
      rd_q     <= 1'b0;
      start_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      ack_q    <= 4'b0000;
      rdv_q    <= 1'b0;
      rdata_q  <= 8'h00;
      rdaddr_q <= 8'h00;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      fair_q   <= 4'd0;
      wcnt_q   <= 10'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      rd_q     <= rd_d;
      start_q  <= start_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      rdv_q    <= rdv_d;
      rdata_q  <= rdata_d;
      rdaddr_q <= rdaddr_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      fair_q   <= fair_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign ack         = ack_q;
  assign rd_valid    = rdv_q;
  assign rd_data     = rdata_q;
  assign rd_addr_o   = rdaddr_q;
  assign proto_start = start_q;
  assign proto_write = write_q;
  assign proto_addr  = addr_q;
  assign proto_data  = data_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter with a latency-programmable
// protocol-engine responder.
module tb_rtc_bus_arbiter;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        Reset;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [3:0]  ack;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [7:0]  rd_addr_o;
  logic        proto_start;
  logic        proto_write;
  logic [7:0]  proto_addr;
  logic [7:0]  proto_data;
  logic        proto_done;
  logic [7:0]  proto_rdata;
  logic        busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  int rdv_cnt = 0;
  int onehot_bad = 0;

  bit       eng_en = 1'b0;
  int       eng_lat = 5;
  bit [7:0] eng_rdata = 8'h00;

  int       seq[$];
  bit [7:0] last_rd;
  bit [7:0] last_rdaddr;

  rtc_bus_arbiter #(.TIMEOUT_CYC(TMO), .RD_FAIR(8)) dut (
    .clk(clk), .Reset(Reset), .req(req),
    .req_addr(req_addr), .req_data(req_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .ack(ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_addr_o(rd_addr_o),
    .proto_start(proto_start), .proto_write(proto_write),
    .proto_addr(proto_addr), .proto_data(proto_data),
    .proto_done(proto_done), .proto_rdata(proto_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    proto_done  = 1'b0;
    proto_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_en && proto_start) begin
        repeat (eng_lat) @(negedge clk);
        proto_rdata = eng_rdata;
        proto_done  = 1'b1;
        @(negedge clk);
        proto_done  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (ack != 4'b0000) ack_cnt++;
    if (rd_valid) rdv_cnt++;
    if (($countones(ack) > 1) || ((ack != 4'b0000) && rd_valid))
      onehot_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (proto_start) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic collect(input int n, input bit drop);
    int cyc;
    cyc = 0;
    seq.delete();
    while ((seq.size() < n) && (cyc < 2000)) begin
      @(negedge clk);
      cyc++;
      if (rd_valid) begin
        seq.push_back(4);
        last_rd     = rd_data;
        last_rdaddr = rd_addr_o;
        if (drop) rd_en = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++)
          if (ack[i]) begin
            seq.push_back(i);
            if (drop) req[i] = 1'b0;
          end
      end
    end
    chk("collect_count", seq.size(), n);
  endtask

  initial begin
    int c, c2, k, a0, r0, bad;
    Reset = 1'b1;
    req = 4'b0000;
    req_addr = 32'h0;
    req_data = 32'h0;
    rd_en = 1'b0;
    rd_addr = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", proto_start, 0);
    chk("rst_ack", ack, 0);
    chk("rst_addr", {proto_write, proto_addr, proto_data}, 0);
    chk("rst_tmo", timeout_err, 0);
    Reset = 1'b0;
    @(negedge clk);

    // single init write, engine answers 5 cycles after start
    eng_en = 1'b1; eng_lat = 5;
    req_addr = 32'h0000_0002;
    req_data = 32'h0000_0010;
    a0 = ack_cnt;
    req = 4'b0001;
    wait_start(4, c);
    chk("w1_start_lat", c, 1);
    chk("w1_write", proto_write, 1);
    chk("w1_addr", proto_addr, 8'h02);
    chk("w1_data", proto_data, 8'h10);
    @(negedge clk);
    chk("w1_start_1cyc", proto_start, 0);
    chk("w1_busy", busy, 1);
    k = 1;
    while ((ack == 4'b0000) && (k < 50)) begin
      @(negedge clk);
      k++;
    end
    chk("w1_ack_lat", k, 6);
    chk("w1_ack", ack, 4'b0001);
    chk("w1_idle", busy, 0);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("w1_ack_once", ack_cnt - a0, 1);

    // engine never answers: timeout, sticky flag, re-issue
    eng_en = 1'b0;
    req_addr = 32'h0000_0700;
    a0 = ack_cnt;
    req = 4'b0010;
    wait_start(4, c);
    chk("to_first_start", c >= 0, 1);
    repeat (15) @(negedge clk);
    chk("to_not_yet", timeout_err, 0);
    wait_start(40, c2);
    chk("to_gap_ok", (c2 >= 0) && (15 + c2 >= TMO + 1) && (15 + c2 <= TMO + 4), 1);
    chk("to_sticky", timeout_err, 1);
    chk("to_same_addr", proto_addr, 8'h07);
    chk("to_no_ack", ack_cnt - a0, 0);
    eng_en = 1'b1; eng_lat = 3;
    collect(1, 1'b1);
    chk("to_final_src", (seq.size() > 0) ? seq[0] : -1, 1);
    chk("to_still_set", timeout_err, 1);

    // reset in WAIT, engine completes afterwards
    eng_lat = 4;
    rd_en = 1'b1; rd_addr = 8'h21; eng_rdata = 8'h99;
    req = 4'b0000;
    collect(1, 1'b1);
    chk("pre_rst_rd", last_rd, 8'h99);
    req_addr = 32'h3300_0000;
    req = 4'b1000;
    wait_start(6, c);
    @(negedge clk);
    Reset = 1'b1; req = 4'b0000;
    @(negedge clk);
    Reset = 1'b0;
    a0 = ack_cnt; r0 = rdv_cnt;
    repeat (8) @(negedge clk);
    chk("mrst_no_ack", ack_cnt - a0, 0);
    chk("mrst_no_rdv", rdv_cnt - r0, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_outs", {proto_write, proto_addr, proto_data, rd_data}, 0);
    chk("mrst_rdaddr", {rd_addr_o, timeout_err}, 0);

    // address change during WAIT is ignored
    eng_lat = 6;
    req_addr = 32'h0000_0002;
    req = 4'b0001;
    wait_start(4, c);
    repeat (2) @(negedge clk);
    req_addr = 32'h0000_0005;
    @(negedge clk);
    chk("hold_addr", proto_addr, 8'h02);
    chk("hold_busy", busy, 1);
    collect(1, 1'b1);
    chk("hold_src", (seq.size() > 0) ? seq[0] : -1, 0);

    // priority: req[2], req[3], then read
    eng_lat = 2; eng_rdata = 8'hA5; rd_addr = 8'h11;
    req_addr = 32'h4433_0000;
    req = 4'b1100; rd_en = 1'b1;
    collect(3, 1'b1);
    bad = 0;
    if (seq.size() == 3) begin
      if (seq[0] != 2) bad++;
      if (seq[1] != 3) bad++;
      if (seq[2] != 4) bad++;
    end else bad = 9;
    chk("prio_order", bad, 0);
    chk("prio_rdata", last_rd, 8'hA5);
    chk("prio_rdaddr", last_rdaddr, 8'h11);
    @(negedge clk);

    // fairness: read forced after every 8th write
    eng_lat = 1; eng_rdata = 8'h45; rd_addr = 8'h3C;
    r0 = rdv_cnt;
    req = 4'b0100; rd_en = 1'b1;
    collect(22, 1'b0);
    req = 4'b0000; rd_en = 1'b0;
    bad = 0;
    for (int i = 0; i < seq.size(); i++)
      if (seq[i] != (((i == 8) || (i == 17)) ? 4 : 2)) bad++;
    chk("fair_pattern", bad, 0);
    chk("fair_reads", rdv_cnt - r0, 2);
    chk("fair_rdata", last_rd, 8'h45);
    chk("fair_rdaddr", last_rdaddr, 8'h3C);
    repeat (6) @(negedge clk);
    chk("end_idle", busy, 0);
    chk("onehot", onehot_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
